sy_ppl_bp_upd_arb: RTL and testbench
====================================

Name: sy_ppl_bp_upd_arb

Overview:
- Sits between the ROB commit stage and the branch predictor's BHT/BTB update ports.
- ROB can retire two control-flow instructions per cycle; the BHT and BTB each take one update per cycle.
- The block queues both commit-side update requests in order and drains them one per cycle, driving both predictor update buses from a registered output stage.
- Exposes backpressure to the ROB, plus idle status for fence/flush sequencing.

Parameters:
- DEPTH, 4, update FIFO entries; power of two, >=2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- upd_vld_i  in  2  per-commit-slot request valid; slot 0 is older
- upd_req_i  in  2 x bp_upd_req_t  request: pc, target, taken, upd_bht, upd_btb
- upd_rdy_o  out  1  both slots may be presented this cycle
- pause_i  in  1  freeze draining; enqueue continues
- bht_update_o  out  bht_update_t  fields: vld, pc, taken
- btb_update_o  out  btb_update_t  fields: vld, pc, target_address
- idle_o  out  1  FIFO empty and no output valid
- ovf_o  out  1  sticky: request arrived while upd_rdy_o=0

Behaviour:
- Reset (rst_i=0, async):
  - FIFO pointers and count = 0; state = IDLE.
  - bht_update_o.vld = 0 and btb_update_o.vld = 0; remaining output fields = 0.
  - upd_rdy_o = 1 (DEPTH>=2); idle_o = 1; ovf_o = 0.
  - Reset mid-drain discards all queued entries.
- Storage:
  - Circular FIFO; rd/wr pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- upd_rdy_o = (DEPTH - count) >= 2. Combinational from count only; never from upd_vld_i.
- Enqueue (at clock edge, when upd_rdy_o=1):
  - A slot is "effective" when upd_vld_i[k] && (upd_bht || upd_btb). Ineffective slots are dropped silently.
  - Effective slots are written in slot order at wr_ptr, wr_ptr+1.
  - A lone slot 1 is written at wr_ptr. n_enq is 0..2.
- Overflow: any upd_vld_i while upd_rdy_o=0 causes no write and sets ovf_o (cleared only by reset).
- Dequeue: at most one entry per edge, when count!=0 (pre-edge) and state=DRAIN.
  - Head loads the output registers: bht_update_o.vld = head.upd_bht; btb_update_o.vld = head.upd_btb; pc/taken/target copied.
  - With no dequeue, both vld bits are 0 the next cycle. Each output valid lasts exactly one cycle.
- count_next = count + n_enq - deq.
  - Simultaneous enqueue and dequeue is legal at every occupancy.
  - At count=DEPTH-2 with 2 enq and 1 deq, result is DEPTH-1.
  - A just-written entry is never dequeued in the same edge (no bypass).
- Latency: request in cycle N into an empty FIFO produces output valid in cycle N+2.
- FSM (one register):
  - IDLE: count=0. Go to DRAIN when n_enq>0 and !pause_i; go to HOLD when n_enq>0 and pause_i.
  - DRAIN: dequeue each cycle. Go to HOLD on pause_i (that edge does not dequeue). Go to IDLE when count_next=0.
  - HOLD: no dequeue. Go to DRAIN when !pause_i and count!=0; go to IDLE when !pause_i and count=0.
- idle_o = (count==0) && !bht_update_o.vld && !btb_update_o.vld. Registered-state function only.
- No flush input: committed updates are never dropped.

Decomposition:
- sy_pkg:
  - bp_upd_req_t {pc[AWTH], target[AWTH], taken, upd_bht, upd_btb}
  - bp_upd_arb_state_e {IDLE, DRAIN, HOLD}
  - Reuse existing bht_update_t / btb_update_t.
- Sub-module sy_ppl_bp_upd_fifo: 2-write/1-read circular FIFO with count. The top keeps the FSM, output registers and ovf logic.

Test Plan:
- Single BHT-only req (pc=0x1000, taken=1) in cycle 0 -> cycle 2: bht_update_o.vld=1, pc=0x1000, taken=1; btb vld=0; idle_o=1 in cycle 3.
- Both slots valid (slot0 pc=0x2000 upd_btb target=0x3000; slot1 pc=0x2004 upd_bht taken=0) -> cycle 2 BTB update 0x2000->0x3000, cycle 3 BHT update 0x2004 not-taken, order preserved.
- DEPTH=4, 2 reqs/cycle for 3 cycles, no pause -> upd_rdy_o drops when count=3; stays high while draining; ovf_o=0; all 6 updates emitted in order.
- pause_i=1 with 3 queued -> no output vld while paused, count holds at 3; release -> 3 consecutive one-cycle updates, then IDLE.
- Request while upd_rdy_o=0 (count=3, pause) -> FIFO unchanged, ovf_o=1 sticky.
- rst_i low for 1 cycle mid-drain with count=2 -> outputs vld=0 immediately (async), idle_o=1, upd_rdy_o=1; no residual updates after release.

Source files
------------

// File: rtl/sy_ppl_bp_upd_arb_pkg.sv
// ----------------------------------------------------------------------------
// sy_ppl_bp_upd_arb_pkg
// Shared types for the branch-predictor update arbiter: commit-side request,
// BHT/BTB update buses and the drain FSM state encoding.
// ----------------------------------------------------------------------------
package sy_ppl_bp_upd_arb_pkg;

    localparam int AWTH = 32;

    typedef struct packed {
        logic [AWTH-1:0] pc;
        logic [AWTH-1:0] target;
        logic            taken;
        logic            upd_bht;
        logic            upd_btb;
    } bp_upd_req_t;

    typedef struct packed {
        logic            vld;
        logic [AWTH-1:0] pc;
        logic            taken;
    } bht_update_t;

    typedef struct packed {
        logic            vld;
        logic [AWTH-1:0] pc;
        logic [AWTH-1:0] target_address;
    } btb_update_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } bp_upd_arb_state_e;

    // A commit slot only matters if it asks for at least one predictor update.
    function automatic logic req_effective(input logic vld, input bp_upd_req_t req);
        return vld && (req.upd_bht || req.upd_btb);
    endfunction

endpackage

// File: rtl/sy_ppl_bp_upd_arb_if.sv
// ----------------------------------------------------------------------------
// sy_ppl_bp_upd_arb_if
// Bundles the ROB-side request handshake and the predictor-side update buses.
//   upd_vld_i/upd_req_i/pause_i : ROB -> arbiter
//   upd_rdy_o                   : arbiter -> ROB backpressure
//   bht_update_o/btb_update_o   : arbiter -> predictor update ports
//   idle_o/ovf_o                : status
// slave modport is the arbiter, master modport is the commit/predictor side.
// ----------------------------------------------------------------------------
interface sy_ppl_bp_upd_arb_if;
    import sy_ppl_bp_upd_arb_pkg::*;

    logic [1:0]             upd_vld_i;
    bp_upd_req_t [1:0]      upd_req_i;
    logic                   upd_rdy_o;
    logic                   pause_i;
    bht_update_t            bht_update_o;
    btb_update_t            btb_update_o;
    logic                   idle_o;
    logic                   ovf_o;

    modport slave (
        input  upd_vld_i, upd_req_i, pause_i,
        output upd_rdy_o, bht_update_o, btb_update_o, idle_o, ovf_o
    );

    modport master (
        output upd_vld_i, upd_req_i, pause_i,
        input  upd_rdy_o, bht_update_o, btb_update_o, idle_o, ovf_o
    );

endinterface

// File: rtl/sy_ppl_bp_upd_fifo.sv
// ----------------------------------------------------------------------------
// sy_ppl_bp_upd_fifo
// Two-write / one-read circular FIFO with occupancy count.
//   clk_i, rst_i  : clock, async active-low reset (pointers/count only)
//   i_wr_vld[1:0] : per-slot write enables; set bits are packed in slot order
//   i_wr_data     : per-slot write data
//   i_rd_en       : pop head (caller guarantees o_count != 0)
//   o_head        : current head entry
//   o_count       : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sy_ppl_bp_upd_fifo
    import sy_ppl_bp_upd_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  i_wr_vld,
    input  bp_upd_req_t [1:0]           i_wr_data,
    input  logic                        i_rd_en,
    output bp_upd_req_t                 o_head,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    bp_upd_req_t    r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_n_enq;
    logic [PW-1:0]  w_wr1_ptr;

    assign w_n_enq   = CW'(i_wr_vld[0]) + CW'(i_wr_vld[1]);
    // Slot 1 lands right behind slot 0, or at wr_ptr itself when alone.
    assign w_wr1_ptr = r_wr_ptr + PW'(i_wr_vld[0]);

    always_ff @(posedge clk_i) begin
        if (i_wr_vld[0]) r_mem[r_wr_ptr]  <= i_wr_data[0];
        if (i_wr_vld[1]) r_mem[w_wr1_ptr] <= i_wr_data[1];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + PW'(i_rd_en);
            r_count  <= r_count + w_n_enq - CW'(i_rd_en);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sy_ppl_bp_upd_arb.sv
// ----------------------------------------------------------------------------
// sy_ppl_bp_upd_arb
// Queues up to two in-order commit-side predictor updates per cycle and
// drains one per cycle onto registered BHT/BTB update buses.
//   clk_i, rst_i : clock, async active-low reset
//   io (slave)   : request handshake, pause, update buses, idle/ovf status
// ----------------------------------------------------------------------------
module sy_ppl_bp_upd_arb
    import sy_ppl_bp_upd_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sy_ppl_bp_upd_arb_if.slave      io
);

    localparam int CW = $clog2(DEPTH) + 1;

    bp_upd_arb_state_e  r_state;
    bp_upd_arb_state_e  w_state_next;
    bht_update_t        r_bht;
    btb_update_t        r_btb;
    logic               r_ovf;

    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_count_next;
    logic [CW-1:0]      w_n_enq;
    logic [1:0]         w_eff;
    logic [1:0]         w_wr;
    logic               w_rdy;
    logic               w_deq;
    bp_upd_req_t        w_head;

    // Room for a full two-slot retire group; depends on registered count only.
    assign w_rdy = (CW'(DEPTH) - w_count) >= CW'(2);

    assign w_eff[0] = req_effective(io.upd_vld_i[0], io.upd_req_i[0]);
    assign w_eff[1] = req_effective(io.upd_vld_i[1], io.upd_req_i[1]);
    assign w_wr     = w_rdy ? w_eff : 2'b00;
    assign w_n_enq  = CW'(w_wr[0]) + CW'(w_wr[1]);

    // Pause takes effect on the same edge: DRAIN does not pop while pause_i.
    assign w_deq        = (r_state == DRAIN) && !io.pause_i && (w_count != '0);
    assign w_count_next = w_count + w_n_enq - CW'(w_deq);

    sy_ppl_bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_wr_vld  (w_wr),
        .i_wr_data (io.upd_req_i),
        .i_rd_en   (w_deq),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_n_enq != '0) w_state_next = io.pause_i ? HOLD : DRAIN;
            DRAIN:   if (io.pause_i)              w_state_next = HOLD;
                     else if (w_count_next == '0) w_state_next = IDLE;
            HOLD:    if (!io.pause_i) w_state_next = (w_count != '0) ? DRAIN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Payload fields hold between pops; only the valids pulse for one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bht <= '0;
            r_btb <= '0;
        end else if (w_deq) begin
            r_bht.vld            <= w_head.upd_bht;
            r_bht.pc             <= w_head.pc;
            r_bht.taken          <= w_head.taken;
            r_btb.vld            <= w_head.upd_btb;
            r_btb.pc             <= w_head.pc;
            r_btb.target_address <= w_head.target;
        end else begin
            r_bht.vld <= 1'b0;
            r_btb.vld <= 1'b0;
        end
    end

    // Any raw valid while not ready is a protocol violation by the ROB.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                        r_ovf <= 1'b0;
        else if ((|io.upd_vld_i) && !w_rdy) r_ovf <= 1'b1;
    end

    assign io.upd_rdy_o    = w_rdy;
    assign io.bht_update_o = r_bht;
    assign io.btb_update_o = r_btb;
    assign io.idle_o       = (w_count == '0) && !r_bht.vld && !r_btb.vld;
    assign io.ovf_o        = r_ovf;

endmodule

// File: tb/tb_sy_ppl_bp_upd_arb.sv
// ----------------------------------------------------------------------------
// tb_sy_ppl_bp_upd_arb
// Directed scenarios followed by randomized traffic, checked every cycle
// against a queue-based reference model of the update arbiter.
// ----------------------------------------------------------------------------
module tb_sy_ppl_bp_upd_arb;
    import sy_ppl_bp_upd_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    sy_ppl_bp_upd_arb_if u_if ();

    sy_ppl_bp_upd_arb #(.DEPTH(DEPTH)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .io    (u_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending updates in commit order, plus the pause seen
    // at the previous edge (draining resumes one cycle after pause releases).
    bp_upd_req_t q[$];
    logic        m_pause_prev;
    logic        m_ovf;
    bht_update_t e_bht;
    btb_update_t e_btb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_rdy();
        return (DEPTH - q.size()) >= 2;
    endfunction

    function automatic bp_upd_req_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                       input logic tk, input logic bht, input logic btb);
        bp_upd_req_t r;
        r.pc = pc; r.target = tgt; r.taken = tk; r.upd_bht = bht; r.upd_btb = btb;
        return r;
    endfunction

    function automatic bp_upd_req_t rnd_req();
        return mk($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    task automatic model_clear();
        q.delete();
        m_pause_prev = 1'b0;
        m_ovf        = 1'b0;
        e_bht        = '0;
        e_btb        = '0;
    endtask

    task automatic check_outputs();
        chk("bht_vld", u_if.bht_update_o.vld, e_bht.vld);
        if (e_bht.vld) chk("bht_pkt", u_if.bht_update_o, e_bht);
        chk("btb_vld", u_if.btb_update_o.vld, e_btb.vld);
        if (e_btb.vld) chk("btb_pkt", u_if.btb_update_o, e_btb);
        chk("idle", u_if.idle_o, (q.size() == 0) && !e_bht.vld && !e_btb.vld);
        chk("ovf", u_if.ovf_o, m_ovf);
        chk("rdy", u_if.upd_rdy_o, model_rdy());
    endtask

    // Check the state left by the previous edge, then present inputs for the
    // next edge and advance the model across it.
    task automatic step(input logic [1:0] v, input bp_upd_req_t r0, input bp_upd_req_t r1,
                        input logic p);
        logic        rdy;
        bp_upd_req_t h;
        @(negedge clk_i);
        check_outputs();
        u_if.upd_vld_i    = v;
        u_if.upd_req_i[0] = r0;
        u_if.upd_req_i[1] = r1;
        u_if.pause_i      = p;
        rdy = model_rdy();
        e_bht.vld = 1'b0;
        e_btb.vld = 1'b0;
        if (q.size() > 0 && !p && !m_pause_prev) begin
            h = q.pop_front();
            e_bht = '{vld: h.upd_bht, pc: h.pc, taken: h.taken};
            e_btb = '{vld: h.upd_btb, pc: h.pc, target_address: h.target};
        end
        if (v != 2'b00 && !rdy) m_ovf = 1'b1;
        else if (rdy) begin
            if (v[0] && (r0.upd_bht || r0.upd_btb)) q.push_back(r0);
            if (v[1] && (r1.upd_bht || r1.upd_btb)) q.push_back(r1);
        end
        m_pause_prev = p;
    endtask

    task automatic idle_steps(input int n, input logic p);
        for (int i = 0; i < n; i++) step(2'b00, '0, '0, p);
    endtask

    task automatic reset_checks();
        chk("rst_bht", u_if.bht_update_o, 34'd0);
        chk("rst_btb", u_if.btb_update_o, 65'd0);
        chk("rst_idle", u_if.idle_o, 1'b1);
        chk("rst_rdy", u_if.upd_rdy_o, 1'b1);
        chk("rst_ovf", u_if.ovf_o, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic reset_mid();
        @(negedge clk_i);
        check_outputs();
        u_if.upd_vld_i = 2'b00;
        u_if.pause_i   = 1'b0;
        #2 rst_i = 1'b0;
        #1 reset_checks();
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        u_if.upd_vld_i = 2'b00;
        u_if.upd_req_i = '0;
        u_if.pause_i   = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        reset_checks();
        rst_i = 1'b1;

        // Lone BHT update, then a mixed BTB/BHT pair preserving order.
        step(2'b01, mk(32'h1000, 32'h0, 1'b1, 1'b1, 1'b0), '0, 1'b0);
        idle_steps(4, 1'b0);
        step(2'b11, mk(32'h2000, 32'h3000, 1'b0, 1'b0, 1'b1),
                    mk(32'h2004, 32'h0, 1'b0, 1'b1, 1'b0), 1'b0);
        idle_steps(4, 1'b0);

        // Lone slot 1 and an ineffective slot 0.
        step(2'b11, mk(32'h2100, 32'h0, 1'b1, 1'b0, 1'b0),
                    mk(32'h2104, 32'h2200, 1'b1, 1'b1, 1'b1), 1'b0);
        idle_steps(3, 1'b0);

        // Three back-to-back pairs, ROB honouring backpressure.
        for (int k = 0; k < 3; k++) begin
            while (!model_rdy()) step(2'b00, '0, '0, 1'b0);
            step(2'b11, mk(32'h4000 + 16*k, 32'h5000 + k, 1'b1, 1'b1, 1'b0),
                        mk(32'h4008 + 16*k, 32'h6000 + k, 1'b0, 1'b0, 1'b1), 1'b0);
        end
        idle_steps(8, 1'b0);

        // Pause with three queued, then release.
        step(2'b11, mk(32'h7000, 32'h7100, 1'b1, 1'b1, 1'b1),
                    mk(32'h7004, 32'h7200, 1'b0, 1'b1, 1'b0), 1'b1);
        step(2'b01, mk(32'h7008, 32'h7300, 1'b1, 1'b0, 1'b1), '0, 1'b1);
        idle_steps(3, 1'b1);

        // Request while not ready: dropped and overflow latched.
        step(2'b01, mk(32'h7777, 32'h0, 1'b1, 1'b1, 1'b0), '0, 1'b1);
        idle_steps(2, 1'b1);
        idle_steps(2, 1'b0);

        // Reset with two entries still pending.
        reset_mid();
        idle_steps(4, 1'b0);

        // Randomized traffic respecting upd_rdy_o, with random pause.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] v;
            v = model_rdy() ? 2'($urandom_range(0, 3)) : 2'b00;
            step(v, rnd_req(), rnd_req(), $urandom_range(0, 3) == 0);
        end
        idle_steps(10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
